audio_note_sequencer: RTL and testbench
=======================================

Name: audio_note_sequencer

Overview:
- Command-driven producer of per-channel tone settings for the 4-channel audio synthesizer.
- Software pushes note commands: channel, period, duration in ticks, preempt flag.
- The block queues them and drives period0..3 and mute[3:0] toward the synthesizer.
- It counts each note's duration down on a tempo tick and mutes the channel when the note expires.

Parameters:
- FIFO_DEPTH, 8, command queue entries (power of two, ≥2)
- TICK_DIV, 50000, HCLK cycles per tempo tick (≥2)
- DUR_W, 8, duration field width in ticks

Ports:
- HCLK  in  1  system clock; the only clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command push request
- cmd_ready  out  1  queue can accept a command
- cmd_chan  in  2  target channel 0..3
- cmd_period  in  PERWIDTH  tone period for the channel
- cmd_dur  in  DUR_W  note length in ticks; 0 means stop the channel
- cmd_preempt  in  1  issue even if the target channel is still playing
- stop_all  in  1  synchronous panic: silence everything, flush the queue
- mute  out  4  per-channel mute, 1 = silent
- period0..period3  out  PERWIDTH each  per-channel period
- busy  out  1  queue non-empty or any channel unmuted
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries

Behaviour:
- Reset (async, resetn=0):
  - mute=4'hF, all periods=0, remaining-duration counters=0.
  - fifo_count=0, tick counter=0, busy=0, cmd_ready=1.
- All outputs are registered in the HCLK domain. The audclk-side consumer synchronizes them.
- cmd_ready = !stop_all && (fifo_count < FIFO_DEPTH). It is combinational from registered state only.
- Push: occurs on an HCLK edge with cmd_valid && cmd_ready. The entry is {chan, period, dur, preempt}.
- Full queue: while fifo_count == FIFO_DEPTH, cmd_ready=0, even in a cycle where a pop occurs.
- Simultaneous push and pop on a non-full queue: fifo_count is unchanged.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle internal pulse in the cycle where the counter equals TICK_DIV-1.
- Issue (at most one per cycle; in-order, head of queue only):
  - Condition: queue non-empty and (mute[head.chan]==1 or head.preempt==1).
  - Action on that edge:
    - pop the head;
    - period[chan] <= head.period;
    - remaining[chan] <= head.dur;
    - mute[chan] <= (head.dur==0).
  - Head-of-line blocking is intentional. If the head targets a playing channel without preempt, later entries for idle channels wait.
- Latency: a command pushed at edge E into an empty queue, targeting an idle channel, is visible on period/mute after edge E+1.
- Countdown: on tick, each channel with mute=0 and remaining>0 decrements remaining.
  - When remaining goes 1 -> 0, the channel mutes on that same edge.
  - The period output holds its last value after muting.
- Same channel, same cycle:
  - An issue takes priority over tick decrement and expiry. Remaining loads head.dur with no decrement.
  - Other channels still decrement normally.
- stop_all=1 at an edge:
  - mute=4'hF, all remaining=0, queue flushed (fifo_count=0).
  - No push or issue that cycle.
  - Periods hold their values.
  - The tick counter keeps running.
- busy = (fifo_count != 0) || (mute != 4'hF), registered.
- Deassertion of resetn mid-note: all state returns to reset values. No partial notes survive.

Decomposition:
- Shared audio header, alongside the existing audio value definitions:
  - PERWIDTH (existing);
  - NUM_AUD_CH=4;
  - default DUR_W and TICK_DIV;
  - packed command-entry width = 2+PERWIDTH+DUR_W+1.
- Sub-module audio_cmd_fifo:
  - synchronous single-clock FIFO;
  - ports: push, pop, flush, din, dout, count, full, empty;
  - dout shows the head combinationally from storage.
- The sequencer holds the tick counter, 4 remaining counters and the issue logic.

Test Plan:
- All tests use TICK_DIV=4.
1. Reset: assert resetn=0 mid-run -> mute=4'hF, periods 0, fifo_count=0, cmd_ready=1, busy=0 immediately (asynchronous).
2. Single note: push {ch1, period=0x120, dur=3} -> after next edge period1=0x120, mute=4'b1101. mute[1] returns to 1 on the 3rd tick, i.e. within 12 HCLK cycles of issue.
3. Blocking vs preempt:
   - Push ch0 dur=5, then ch0 dur=2 (preempt=0), then ch2 dur=1 -> the 2nd and 3rd entries wait until ch0 expires.
   - Repeat with preempt=1 on the 2nd entry -> it issues on the cycle after the first, and remaining0 reloads to 2.
4. Full queue: push 9 commands to a blocked channel -> cmd_ready=0 after 8 accepted, fifo_count=8, and the 9th is held off by the producer until a pop.
5. Issue vs expiry collision: align a preempting ch3 command so it issues on the tick where remaining3 would go 1->0 -> mute[3] stays 0 and remaining3 equals the new dur.
6. dur=0 and stop_all:
   - A dur=0 command to a playing channel -> that channel mutes on issue.
   - stop_all with 4 queued entries and all channels playing -> mute=4'hF, fifo_count=0 next edge, cmd_ready=0 during the pulse, periods unchanged.

Source files
------------

// File: rtl/audio_note_sequencer_pkg.sv
// Shared audio definitions: channel count, tone period width and the
// packed layout of a queued note command.
package audio_note_sequencer_pkg;

  localparam int PERWIDTH       = 12;
  localparam int NUM_AUD_CH     = 4;
  localparam int DEF_DUR_W      = 8;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_FIFO_DEPTH = 8;

  // Command entry is packed as {chan[1:0], period, dur, preempt}.
  function automatic int cmd_entry_w(input int dur_w);
    return 2 + PERWIDTH + dur_w + 1;
  endfunction

endpackage

// File: rtl/audio_note_sequencer_cmd_fifo.sv
// Single-clock command FIFO; the head entry is read straight out of storage
// so the sequencer can decide on an issue in the same cycle.
module audio_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 23
) (
  input  logic                   HCLK,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge HCLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/audio_note_sequencer.sv
// Note sequencer: queues note commands, issues them in order to the four
// synthesizer channels and mutes each channel when its duration runs out.
module audio_note_sequencer
  import audio_note_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic                        HCLK,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_chan,
  input  logic [PERWIDTH-1:0]         cmd_period,
  input  logic [DUR_W-1:0]            cmd_dur,
  input  logic                        cmd_preempt,
  input  logic                        stop_all,
  output logic [3:0]                  mute,
  output logic [PERWIDTH-1:0]         period0,
  output logic [PERWIDTH-1:0]         period1,
  output logic [PERWIDTH-1:0]         period2,
  output logic [PERWIDTH-1:0]         period3,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CMD_W = cmd_entry_w(DUR_W);
  localparam int CW    = $clog2(FIFO_DEPTH);
  localparam int TW    = $clog2(TICK_DIV);

  logic [CMD_W-1:0]      head;
  logic [1:0]            head_chan;
  logic [PERWIDTH-1:0]   head_period;
  logic [DUR_W-1:0]      head_dur;
  logic                  head_preempt;
  logic                  fifo_full, fifo_empty;
  logic                  push, issue, tick;
  logic [TW-1:0]         tick_cnt_reg;
  logic                  busy_reg;
  logic [CW:0]           count_next;
  logic [NUM_AUD_CH-1:0] mute_all_reg, mute_all_next;
  logic [PERWIDTH-1:0]   period_all [NUM_AUD_CH];

  assign head_chan    = head[CMD_W-1 -: 2];
  assign head_period  = head[DUR_W+1 +: PERWIDTH];
  assign head_dur     = head[1 +: DUR_W];
  assign head_preempt = head[0];

  assign cmd_ready = !stop_all && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // Only the head may issue; a blocked head stalls everything behind it.
  assign issue     = !fifo_empty && !stop_all && (mute_all_reg[head_chan] || head_preempt);
  assign tick      = (tick_cnt_reg == TW'(TICK_DIV - 1));

  audio_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .HCLK   (HCLK),
    .resetn (resetn),
    .push   (push),
    .pop    (issue),
    .flush  (stop_all),
    .din    ({cmd_chan, cmd_period, cmd_dur, cmd_preempt}),
    .dout   (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge HCLK or negedge resetn) begin
    if (!resetn) tick_cnt_reg <= '0;
    else         tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AUD_CH; gi++) begin : g_chan
      logic [PERWIDTH-1:0] period_reg, period_next;
      logic [DUR_W-1:0]    remaining_reg, remaining_next;
      logic                mute_reg, mute_next;

      // Issue wins over the tick for the same channel, so a reload never loses a tick.
      always_comb begin
        period_next    = period_reg;
        remaining_next = remaining_reg;
        mute_next      = mute_reg;
        if (stop_all) begin
          remaining_next = '0;
          mute_next      = 1'b1;
        end else if (issue && head_chan == 2'(gi)) begin
          period_next    = head_period;
          remaining_next = head_dur;
          mute_next      = (head_dur == '0);
        end else if (tick && !mute_reg && remaining_reg != '0) begin
          remaining_next = remaining_reg - DUR_W'(1);
          if (remaining_reg == DUR_W'(1)) mute_next = 1'b1;
        end
      end

      always_ff @(posedge HCLK or negedge resetn) begin
        if (!resetn) begin
          period_reg    <= '0;
          remaining_reg <= '0;
          mute_reg      <= 1'b1;
        end else begin
          period_reg    <= period_next;
          remaining_reg <= remaining_next;
          mute_reg      <= mute_next;
        end
      end

      assign mute_all_reg[gi]  = mute_reg;
      assign mute_all_next[gi] = mute_next;
      assign period_all[gi]    = period_reg;
    end
  endgenerate

  always_comb begin
    count_next = '0;
    if (!stop_all) count_next = fifo_count + (CW+1)'(push) - (CW+1)'(issue);
  end

  // busy is built from next-state values so it agrees with mute/fifo_count in the same cycle.
  always_ff @(posedge HCLK or negedge resetn) begin
    if (!resetn) busy_reg <= 1'b0;
    else         busy_reg <= (count_next != '0) || (mute_all_next != '1);
  end

  assign mute    = mute_all_reg;
  assign busy    = busy_reg;
  assign period0 = period_all[0];
  assign period1 = period_all[1];
  assign period2 = period_all[2];
  assign period3 = period_all[3];

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Self-checking bench: queue-level note model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_audio_note_sequencer;
  import audio_note_sequencer_pkg::*;

  localparam int DEPTH = 8;
  localparam int TDIV  = 4;
  localparam int DW    = 8;
  localparam int PW    = PERWIDTH;

  logic          HCLK = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready, cmd_preempt, stop_all, busy;
  logic [1:0]    cmd_chan;
  logic [PW-1:0] cmd_period, period0, period1, period2, period3;
  logic [DW-1:0] cmd_dur;
  logic [3:0]    mute;
  logic [3:0]    fifo_count;

  audio_note_sequencer #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TDIV), .DUR_W(DW)) dut (
    .HCLK(HCLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_period(cmd_period), .cmd_dur(cmd_dur),
    .cmd_preempt(cmd_preempt), .stop_all(stop_all), .mute(mute),
    .period0(period0), .period1(period1), .period2(period2), .period3(period3),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]    chan;
    logic [PW-1:0] per;
    logic [DW-1:0] dur;
    logic          pre;
  } cmd_t;

  cmd_t          q[$];
  int            m_rem [4];
  bit            m_mute[4];
  logic [PW-1:0] m_per [4];
  int            m_tc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mvec();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_mute[c];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < 4; c++) begin
      m_rem[c] = 0; m_mute[c] = 1'b1; m_per[c] = '0;
    end
    m_tc = 0;
  endtask

  // One clock edge of the note rules, evaluated on pre-edge state.
  task automatic model_step();
    bit   tk, iss, rdy;
    cmd_t h;
    tk   = (m_tc == TDIV - 1);
    m_tc = (m_tc + 1) % TDIV;
    if (stop_all) begin
      q.delete();
      for (int c = 0; c < 4; c++) begin m_mute[c] = 1'b1; m_rem[c] = 0; end
      return;
    end
    rdy = (q.size() < DEPTH);
    iss = (q.size() > 0) && (m_mute[q[0].chan] || q[0].pre);
    if (iss) h = q.pop_front();
    for (int c = 0; c < 4; c++) begin
      if (iss && int'(h.chan) == c) begin
        m_per[c] = h.per; m_rem[c] = int'(h.dur); m_mute[c] = (h.dur == 0);
      end else if (tk && !m_mute[c] && m_rem[c] > 0) begin
        m_rem[c]--;
        if (m_rem[c] == 0) m_mute[c] = 1'b1;
      end
    end
    if (cmd_valid && rdy) begin
      h.chan = cmd_chan; h.per = cmd_period; h.dur = cmd_dur; h.pre = cmd_preempt;
      q.push_back(h);
    end
  endtask

  task automatic compare();
    chk("mute", mute, mvec());
    chk("period0", period0, m_per[0]);
    chk("period1", period1, m_per[1]);
    chk("period2", period2, m_per[2]);
    chk("period3", period3, m_per[3]);
    chk("fifo_count", fifo_count, q.size());
    chk("busy", busy, (q.size() != 0) || (mvec() != 4'hF));
  endtask

  task automatic cycle();
    #1 chk("cmd_ready", cmd_ready, !stop_all && (q.size() < DEPTH));
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    compare();
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [PW-1:0] p,
                       input logic [DW-1:0] d, input logic pr, input logic st);
    cmd_valid = v; cmd_chan = ch; cmd_period = p; cmd_dur = d; cmd_preempt = pr; stop_all = st;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin idle(1); n++; end
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic async_reset_check();
    #2 resetn = 1'b0;
    #1;
    chk("rst_mute", mute, 4'hF);
    chk("rst_period0", period0, 0);
    chk("rst_period3", period3, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    model_reset();
    @(posedge HCLK);
    @(negedge HCLK);
    resetn = 1'b1;
    compare();
  endtask

  initial begin
    logic [PW-1:0] sp0, sp1, sp2, sp3;
    int n;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_chan = '0; cmd_period = '0;
    cmd_dur = '0; cmd_preempt = 1'b0; stop_all = 1'b0;
    model_reset();
    repeat (2) @(negedge HCLK);
    chk("init_mute", mute, 4'hF);
    chk("init_busy", busy, 1'b0);
    chk("init_ready", cmd_ready, 1'b1);
    resetn = 1'b1;

    // Single note: visible one edge after the push edge, expires on the 3rd tick.
    drive(1'b1, 2'd1, 12'h120, 8'd3, 1'b0, 1'b0);
    idle(1);
    chk("single_period1", period1, 12'h120);
    chk("single_mute", mute, 4'b1101);
    n = 0;
    while (mute[1] == 1'b0 && n < 14) begin idle(1); n++; end
    chk("single_len_9_12", (n >= 9 && n <= 12), 1'b1);
    wait_idle(20);

    // Head-of-line blocking without preempt.
    drive(1'b1, 2'd0, 12'h010, 8'd5, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 12'h011, 8'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 12'h022, 8'd1, 1'b0, 1'b0);
    chk("block_count", fifo_count, 2);
    idle(8);
    chk("block_ch2_waits", mute[2], 1'b1);
    chk("block_count_hold", fifo_count, 2);
    wait_idle(80);

    // Preempt reloads a playing channel on the next cycle.
    drive(1'b1, 2'd0, 12'h030, 8'd5, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 12'h031, 8'd2, 1'b1, 1'b0);
    idle(1);
    chk("pre_count", fifo_count, 0);
    chk("pre_period0", period0, 12'h031);
    chk("pre_playing", mute[0], 1'b0);
    idle(9);
    chk("pre_short_expiry", mute[0], 1'b1);
    wait_idle(20);

    // Full queue behind a blocked channel.
    drive(1'b1, 2'd0, 12'h055, 8'd20, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd0, PW'(i), 8'd1, 1'b0, 1'b0);
    chk("full_count", fifo_count, 8);
    chk("full_ready", cmd_ready, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd0, 12'h099, 8'd1, 1'b0, 1'b0);
    chk("full_hold", fifo_count, 8);
    n = 0;
    while (fifo_count == 4'd8 && n < 100) begin drive(1'b1, 2'd0, 12'h099, 8'd1, 1'b0, 1'b0); n++; end
    chk("full_pop_seen", fifo_count, 7);
    drive(1'b1, 2'd0, 12'h099, 8'd1, 1'b0, 1'b0);
    chk("full_ninth_in", fifo_count, 8);
    wait_idle(300);

    // Preempting issue lands on the tick that would expire ch3.
    drive(1'b1, 2'd3, 12'h333, 8'd2, 1'b0, 1'b0);
    idle(1);
    n = 0;
    while (!(m_rem[3] == 1 && m_tc == TDIV - 2) && n < 20) begin idle(1); n++; end
    drive(1'b1, 2'd3, 12'h3AB, 8'd7, 1'b1, 1'b0);
    idle(1);
    chk("coll_mute3", mute[3], 1'b0);
    chk("coll_period3", period3, 12'h3AB);
    idle(20);
    chk("coll_still_playing", mute[3], 1'b0);
    wait_idle(40);

    // dur=0 silences a playing channel on issue.
    drive(1'b1, 2'd2, 12'h200, 8'd50, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 2'd2, 12'h201, 8'd0, 1'b1, 1'b0);
    idle(1);
    chk("dur0_mute2", mute[2], 1'b1);
    chk("dur0_period2", period2, 12'h201);

    // stop_all with all channels playing and four queued.
    for (int c = 0; c < 4; c++) drive(1'b1, 2'(c), PW'(12'h400 + c), 8'd100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd0, 12'h0AA, 8'd5, 1'b0, 1'b0);
    idle(1);
    chk("stop_pre_count", fifo_count, 4);
    chk("stop_pre_mute", mute, 4'h0);
    sp0 = m_per[0]; sp1 = m_per[1]; sp2 = m_per[2]; sp3 = m_per[3];
    stop_all = 1'b1; cmd_valid = 1'b1;
    #1 chk("stop_ready", cmd_ready, 1'b0);
    cycle();
    stop_all = 1'b0; cmd_valid = 1'b0;
    chk("stop_mute", mute, 4'hF);
    chk("stop_count", fifo_count, 0);
    chk("stop_p0", period0, 12'h400);
    chk("stop_p3", period3, 12'h403);
    chk("stop_p1_hold", period1, sp1);
    chk("stop_p2_hold", period2, sp2);
    chk("stop_p0_hold", period0, sp0);
    chk("stop_p3_hold", period3, sp3);

    // Randomized traffic with one asynchronous reset in the middle of notes.
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        cmd_valid = 1'b0; stop_all = 1'b0;
        async_reset_check();
      end else begin
        drive(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), PW'($urandom),
              DW'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
